// File: rtl/serial_word_comparator.sv
// serial_word_comparator
// Serial magnitude comparator for framed words streamed one digit per beat.
// WIDTH/DIGIT_W beats form one frame. Digits arrive MSB-first or LSB-first,
// selected at compile time. Operands are either unsigned or two's complement.
// One registered a/b ordering result is produced per completed frame, and it
// is qualified by a one-cycle res_valid pulse.
// Optional feature: define SERIAL_CMP_ABORT_EN to add an 'abort' input. Abort
// cancels the partial frame and keeps the last result.
module serial_word_comparator #(
    parameter int WIDTH     = 8,
    parameter int DIGIT_W   = 1,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SERIAL_CMP_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               busy,
    output logic               res_valid,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b
);

    localparam int BEATS = WIDTH / DIGIT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // The beat that carries the most significant digit. Only that digit is
    // compared as signed.
    localparam logic [CNT_W-1:0] MS_BEAT = (MSB_FIRST != 0) ? '0 : LAST_BEAT;

    logic [CNT_W-1:0] cnt_reg;
    logic             run_lt_reg;
    logic             run_eq_reg;
    logic             lt_reg;
    logic             eq_reg;
    logic             res_valid_reg;

    logic             d_lt;
    logic             d_eq;
    logic             run_lt_next;
    logic             run_eq_next;
    logic             abort_req;

`ifdef SERIAL_CMP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Compare the current digits, then fold the result into the running state.
    always_comb begin
        d_eq = (a == b);
        if ((SIGNED != 0) && (cnt_reg == MS_BEAT)) begin
            d_lt = ($signed(a) < $signed(b));
        end else begin
            d_lt = (a < b);
        end

        run_lt_next = run_lt_reg;
        run_eq_next = run_eq_reg;
        if (MSB_FIRST != 0) begin
            // The first differing digit decides the result. Later digits are ignored.
            if (run_eq_reg) begin
                run_lt_next = d_lt;
                run_eq_next = d_eq;
            end
        end else begin
            // A later digit is more significant, so any later difference overrides.
            if (!d_eq) begin
                run_lt_next = d_lt;
                run_eq_next = 1'b0;
            end
        end
    end

    // Beat counting, running state, and result registration at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            run_lt_reg    <= 1'b0;
            run_eq_reg    <= 1'b1;
            lt_reg        <= 1'b0;
            eq_reg        <= 1'b1;
            res_valid_reg <= 1'b0;
        end else if (abort_req) begin
            cnt_reg       <= '0;
            run_lt_reg    <= 1'b0;
            run_eq_reg    <= 1'b1;
            res_valid_reg <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            if (in_valid) begin
                if (cnt_reg == LAST_BEAT) begin
                    cnt_reg       <= '0;
                    lt_reg        <= run_lt_next;
                    eq_reg        <= run_eq_next;
                    res_valid_reg <= 1'b1;
                    run_lt_reg    <= 1'b0;
                    run_eq_reg    <= 1'b1;
                end else begin
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    run_lt_reg <= run_lt_next;
                    run_eq_reg <= run_eq_next;
                end
            end
        end
    end

    assign busy        = (cnt_reg != '0);
    assign res_valid   = res_valid_reg;
    assign a_less_b    = lt_reg;
    assign a_eq_b      = eq_reg;
    assign a_greater_b = ~lt_reg & ~eq_reg;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Testbench for serial_word_comparator. It runs two instances side by side:
//   u_a: WIDTH=16, DIGIT_W=4, MSB-first, signed
//   u_b: WIDTH=8,  DIGIT_W=1, LSB-first, unsigned
// A word-level reference model produces the expected result for each frame,
// which goes into a per-instance queue. A per-instance monitor pops an entry
// whenever res_valid is seen and compares the flags and the arrival cycle.
module tb_serial_word_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0;
    logic [3:0] a_a = '0, a_b = '0;
    logic       a_busy, a_rv, a_lt, a_eq, a_gt;
    logic       b_valid = 1'b0;
    logic [0:0] b_a = '0, b_b = '0;
    logic       b_busy, b_rv, b_lt, b_eq, b_gt;
`ifdef SERIAL_CMP_ABORT_EN
    logic       abort_a = 1'b0;
    logic       abort_b = 1'b0;
`endif

    serial_word_comparator #(.WIDTH(16), .DIGIT_W(4), .MSB_FIRST(1), .SIGNED(1)) u_a (
        .clk(clk), .rst(rst),
`ifdef SERIAL_CMP_ABORT_EN
        .abort(abort_a),
`endif
        .in_valid(a_valid), .a(a_a), .b(a_b), .busy(a_busy), .res_valid(a_rv),
        .a_less_b(a_lt), .a_eq_b(a_eq), .a_greater_b(a_gt)
    );

    serial_word_comparator #(.WIDTH(8), .DIGIT_W(1), .MSB_FIRST(0), .SIGNED(0)) u_b (
        .clk(clk), .rst(rst),
`ifdef SERIAL_CMP_ABORT_EN
        .abort(abort_b),
`endif
        .in_valid(b_valid), .a(b_a), .b(b_b), .busy(b_busy), .res_valid(b_rv),
        .a_less_b(b_lt), .a_eq_b(b_eq), .a_greater_b(b_gt)
    );

    typedef struct {
        logic [2:0] flags;   // {lt, eq, gt}
        int         cyc;     // cycle in which res_valid must be seen
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Word-level reference: plain integer comparison of the w-bit operands.
    function automatic logic [2:0] ref_cmp(input logic [15:0] av, input logic [15:0] bv,
                                           input int w, input bit sgn);
        longint x, y, m;
        m = (64'sd1 <<< w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (sgn && x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        if (sgn && y >= (64'sd1 <<< (w - 1))) y = y - (64'sd1 <<< w);
        return {x < y, x == y, x > y};
    endfunction

    // Monitor for u_a: each res_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (a_rv) begin
            if (qa.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_res_valid: got pulse required none (cycle %0d)", cyc);
            end else begin
                e = qa.pop_front();
                chk("a_flags", {29'd0, a_lt, a_eq, a_gt}, {29'd0, e.flags});
                chk("a_latency", cyc, e.cyc);
            end
        end
    end

    // Monitor for u_b.
    always @(negedge clk) begin
        exp_t e;
        if (b_rv) begin
            if (qb.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_res_valid: got pulse required none (cycle %0d)", cyc);
            end else begin
                e = qb.pop_front();
                chk("b_flags", {29'd0, b_lt, b_eq, b_gt}, {29'd0, e.flags});
                chk("b_latency", cyc, e.cyc);
            end
        end
    end

    // Stream nbeats digits MSB-first into u_a, with random idle gaps of
    // 0..maxgap cycles between beats. A full frame queues an expected result.
    task automatic send_a(input logic [15:0] av, input logic [15:0] bv, input int nbeats, input int maxgap);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            chk("a_busy", {31'd0, a_busy}, {31'd0, i != 0});
            a_valid = 1'b1;
            a_a = av[15-4*i -: 4];
            a_b = bv[15-4*i -: 4];
            if (i == 3) begin
                e.flags = ref_cmp(av, bv, 16, 1'b1);
                e.cyc   = cyc + 1;
                qa.push_back(e);
            end
            if (i < nbeats - 1) begin
                repeat ($urandom_range(maxgap, 0)) begin
                    @(negedge clk);
                    a_valid = 1'b0;
                end
            end
        end
    endtask

    // Stream nbeats bits LSB-first into u_b.
    task automatic send_b(input logic [7:0] av, input logic [7:0] bv, input int nbeats, input int maxgap);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            chk("b_busy", {31'd0, b_busy}, {31'd0, i != 0});
            b_valid = 1'b1;
            b_a = av[i];
            b_b = bv[i];
            if (i == 7) begin
                e.flags = ref_cmp({8'd0, av}, {8'd0, bv}, 8, 1'b0);
                e.cyc   = cyc + 1;
                qb.push_back(e);
            end
            if (i < nbeats - 1) begin
                repeat ($urandom_range(maxgap, 0)) begin
                    @(negedge clk);
                    b_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Random operand pair. Biased toward equal words and single-bit differences.
    function automatic logic [31:0] rnd_pair(input int w);
        logic [15:0] x, y;
        int sel;
        x = 16'($urandom);
        sel = $urandom_range(2, 0);
        if (sel == 0) y = x;
        else if (sel == 1) y = x ^ (16'd1 << $urandom_range(w - 1, 0));
        else y = 16'($urandom);
        return {x, y};
    endfunction

    initial begin
        logic [31:0] p;
        repeat (3) @(negedge clk);
        // Reset state of both instances.
        chk("a_rst_eq", {31'd0, a_eq}, 1);
        chk("a_rst_lt", {31'd0, a_lt}, 0);
        chk("a_rst_gt", {31'd0, a_gt}, 0);
        chk("a_rst_rv", {31'd0, a_rv}, 0);
        chk("a_rst_busy", {31'd0, a_busy}, 0);
        chk("b_rst_eq", {31'd0, b_eq}, 1);
        chk("b_rst_lt", {31'd0, b_lt}, 0);
        chk("b_rst_rv", {31'd0, b_rv}, 0);
        chk("b_rst_busy", {31'd0, b_busy}, 0);
        rst = 1'b0;

        // u_a directed frames: gaps, signed extremes, equality.
        send_a(16'h1234, 16'h1243, 4, 3); idle(2);
        send_a(16'h8000, 16'h7FFF, 4, 0); idle(1);
        send_a(16'hABCD, 16'hABCD, 4, 2); idle(1);
        send_a(16'hFFFF, 16'h0001, 4, 1); idle(2);
        // Partial frame followed by reset: the frame is dropped and the flags return to eq.
        send_a(16'h0010, 16'h000F, 3, 0);
        @(negedge clk); a_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("a_rst_mid_eq", {31'd0, a_eq}, 1);
        chk("a_rst_mid_busy", {31'd0, a_busy}, 0);
        send_a(16'h0010, 16'h000F, 4, 0);
        // Back-to-back: greater, then equal.
        send_a(16'h0100, 16'h00FF, 4, 0);
        send_a(16'h5555, 16'h5555, 4, 0); idle(2);
        for (int k = 0; k < 20; k++) begin
            p = rnd_pair(16);
            send_a(p[31:16], p[15:0], 4, 2);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 0));
        end
        idle(3);

        // u_b directed frames, LSB-first unsigned.
        send_b(8'h01, 8'h80, 8, 0); idle(1);
        send_b(8'h81, 8'h80, 8, 2); idle(1);
        send_b(8'h5A, 8'h5C, 8, 1); idle(1);
        send_b(8'h80, 8'h7F, 8, 0);
        send_b(8'hFF, 8'hFF, 8, 0); idle(2);
        for (int k = 0; k < 20; k++) begin
            p = rnd_pair(8);
            send_b(p[23:16], p[7:0], 8, 1);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 0));
        end
        idle(2);

`ifdef SERIAL_CMP_ABORT_EN
        // Abort at beat 4. Abort wins over a simultaneous valid beat. No pulse, flags held.
        send_b(8'h5A, 8'h5C, 8, 0);
        send_b(8'h33, 8'h11, 4, 0);
        @(negedge clk); b_a = 1'b1; b_b = 1'b0; abort_b = 1'b1;
        @(negedge clk); abort_b = 1'b0; b_valid = 1'b0;
        chk("b_abort_busy", {31'd0, b_busy}, 0);
        chk("b_abort_lt_held", {31'd0, b_lt}, 1);
        chk("b_abort_eq_held", {31'd0, b_eq}, 0);
        send_b(8'h10, 8'h0F, 8, 0); idle(2);
`endif

        // Every queued result must have arrived.
        idle(4);
        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
Parametrised serial magnitude comparator for framed words streamed one digit per beat. It generalises the 1-bit serial comparator in four ways: configurable word length, configurable digit width, compile-time MSB-first or LSB-first order, and optional two's-complement compare. A result is produced once per completed frame, with a valid strobe. It sits between serial links or bit-serial datapaths and control logic that needs a/b ordering.

Parameters:
WIDTH, 8, word length in bits; must be a multiple of DIGIT_W, and WIDTH/DIGIT_W >= 1.
DIGIT_W, 1, bits per beat on a and b.
MSB_FIRST, 1, 1 = most significant digit first; 0 = least significant digit first.
SIGNED, 0, 1 = operands are two's complement; 0 = unsigned.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  beat qualifier; a and b are sampled only when it is 1.
a  input  DIGIT_W  current digit of operand A.
b  input  DIGIT_W  current digit of operand B.
busy  output  1  1 while a frame is partially received (beat count != 0).
res_valid  output  1  one-cycle pulse when a new result is presented.
a_less_b  output  1  registered result; held until the next result.
a_eq_b  output  1  registered result; held until the next result.
a_greater_b  output  1  registered result; held until the next result.

Behaviour:
- BEATS = WIDTH/DIGIT_W. The beat counter has range 0..BEATS-1 and increments on in_valid. It wraps to 0 after the last beat.
- in_valid low stalls the frame. There is no timeout, and gaps of any length are legal.
- Running state: run_lt and run_eq. Both are reset at frame start to run_eq=1, run_lt=0.
- Per-beat digit compare d_lt / d_eq:
  - Unsigned in general.
  - Signed compare (DIGIT_W-bit two's complement) only on the most significant digit, and only when SIGNED=1.
  - The most significant digit is beat 0 when MSB_FIRST=1, and beat BEATS-1 when MSB_FIRST=0.
- MSB-first update:
  - If run_eq: run_lt <= d_lt; run_eq <= d_eq.
  - Otherwise hold (the decision is frozen at the first differing digit).
- LSB-first update:
  - If d_eq: hold.
  - Otherwise run_lt <= d_lt; run_eq <= 0 (the latest unequal digit dominates).
- On the beat with count == BEATS-1, the final values are computed from that beat combined with the running state:
  - Registered into the flags on the next posedge.
  - res_valid = 1 for exactly one cycle.
  - Running state re-initialised.
- Latency: flags update and res_valid asserts in the cycle after the last beat is accepted.
- Back-to-back frames: the first beat of the next frame may arrive in the same cycle that res_valid is high.
- a_greater_b = ~a_less_b & ~a_eq_b. Exactly one flag is high at all times.
- Reset values: a_eq_b=1, a_less_b=0, a_greater_b=0, res_valid=0, busy=0, beat count 0, run_eq=1, run_lt=0.
- Reset mid-frame discards the partial frame. No res_valid is produced for it.
- BEATS=1 is legal. Each valid beat is a full frame, and busy stays 0.

Optional Feature:
SERIAL_CMP_ABORT_EN: when defined, adds input port abort (1 bit).
- abort=1 at a posedge: beat count and running state return to their frame-start values, and no res_valid is produced.
- Abort has priority over in_valid in the same cycle.
- Flags keep their last result. busy drops the next cycle.

When undefined: the port is absent and frames can only be cancelled by rst.

Test Plan:
1. WIDTH=8, DIGIT_W=1, MSB-first unsigned: a=0x5A, b=0x5C → one res_valid pulse the cycle after beat 7, with a_less_b=1. Next frame a=b=0xFF → a_eq_b=1.
2. Same config, signed: a=0x80 (-128), b=0x7F → a_less_b=1. Repeat with SIGNED=0 → a_greater_b=1.
3. MSB_FIRST=0, DIGIT_W=1: a=0x01, b=0x80 streamed LSB-first → a_less_b=1. Then a=0x81, b=0x80 → a_greater_b=1.
4. WIDTH=16, DIGIT_W=4, MSB-first: a=0x1234, b=0x1243, with in_valid gaps of 0–3 cycles between beats → a_less_b=1. busy is high from beat 1 until res_valid.
5. Frame interrupted: assert rst after 3 of 8 beats → no res_valid, flags at eq=1. A fresh frame a=0x10, b=0x0F then gives a_greater_b=1.
6. Back-to-back frames with no idle cycle: a_greater_b, then a_eq_b. Exactly two res_valid pulses 8 cycles apart. With SERIAL_CMP_ABORT_EN, abort at beat 4 → no pulse, and the prior flags are held.
